// File: rtl/ram_access_ctrl.sv
// CPU-side initiator for the 256x8 RAM: turns a req/ack transaction into the
// RAM's address phase and write-strobe or read-capture data phase.
module ram_access_ctrl #(
    parameter int unsigned READ_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       man_mode,
    output logic       ack,
    output logic       busy,
    output logic [7:0] rdata,
    output logic [7:0] bus_out,
    input  logic [7:0] ram_bus_in,
    output logic       A_D,
    output logic       CU_in,
    output logic       ST,
    output logic       WR,
    output logic       RD,
    output logic       MW
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] W_READ_WAIT = 3'(READ_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic       w_accept;
    logic       w_capture;
    logic       r_we;
    logic [7:0] r_wdata;
    logic [2:0] r_cnt;

    logic       w_ack, w_busy, w_a_d, w_cu_in, w_st, w_wr, w_rd, w_mw;
    logic [7:0] w_bus;
    logic       r_ack, r_busy, r_a_d, r_cu_in, r_st, r_wr, r_rd, r_mw;
    logic [7:0] r_bus;
    logic [7:0] r_rdata;

    // Next-state decode; manual mode outranks a pending request in IDLE.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req && !man_mode) begin
                    w_next   = S_ADDR;
                    w_accept = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ADDR:  w_next = r_we ? S_WRITE : S_READ;
            S_WRITE: w_next = S_DONE;
            S_READ: begin
                if (r_cnt == 3'd0) begin
                    w_next    = S_DONE;
                    w_capture = 1'b1;
                end else begin
                    w_next = S_READ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output values for the coming state, registered so they hold the whole cycle.
    always_comb begin
        w_ack   = 1'b0;
        w_busy  = 1'b1;
        w_a_d   = 1'b0;
        w_cu_in = 1'b0;
        w_st    = 1'b0;
        w_wr    = 1'b0;
        w_rd    = 1'b0;
        w_mw    = 1'b0;
        w_bus   = 8'h00;
        case (w_next)
            S_IDLE: begin
                w_busy = 1'b0;
                w_mw   = man_mode;
            end
            S_ADDR: begin
                w_a_d   = 1'b1;
                w_cu_in = 1'b1;
                w_bus   = addr;
            end
            S_WRITE: begin
                w_st  = 1'b1;
                w_wr  = 1'b1;
                w_bus = r_wdata;
            end
            S_READ:  w_rd  = 1'b1;
            S_DONE:  w_ack = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // State, request latches, wait counter and read capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_wdata <= 8'h00;
            r_cnt   <= 3'd0;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= we;
                r_wdata <= wdata;
            end
            if (r_state == S_ADDR) begin
                r_cnt <= W_READ_WAIT;
            end else if (r_state == S_READ && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_capture) begin
                r_rdata <= ram_bus_in;
            end
        end
    end

    // Output registers; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_a_d   <= 1'b0;
            r_cu_in <= 1'b0;
            r_st    <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_mw    <= 1'b0;
            r_bus   <= 8'h00;
        end else begin
            r_ack   <= w_ack;
            r_busy  <= w_busy;
            r_a_d   <= w_a_d;
            r_cu_in <= w_cu_in;
            r_st    <= w_st;
            r_wr    <= w_wr;
            r_rd    <= w_rd;
            r_mw    <= w_mw;
            r_bus   <= w_bus;
        end
    end

    assign ack     = r_ack;
    assign busy    = r_busy;
    assign rdata   = r_rdata;
    assign bus_out = r_bus;
    assign A_D     = r_a_d;
    assign CU_in   = r_cu_in;
    assign ST      = r_st;
    assign WR      = r_wr;
    assign RD      = r_rd;
    assign MW      = r_mw;

endmodule
